// File: rtl/cby_cfg_shadow_mux.sv
// cby_cfg_shadow_mux: parameterised vertical connection block.
//   Taps a bidirectional Y-channel onto NUM_IPIN grid input pins. Each pin
//   has a MUX_SIZE-input mux with a binary select. Selects are loaded over
//   the ccff scan chain into a shift register (cfg). They are copied into a
//   shadow register (active) only on commit, which is the edge after
//   config_enable falls. Programming therefore never disturbs the pins.
//   The block also checks the shift count and raises a done flag.
// Ports:
//   prog_clk, pReset                   config clock, async active-high reset
//   config_enable, ccff_head/ccff_tail shift enable and scan-chain I/O
//   chany_bottom_in/top_in             channel tracks in from each side
//   chany_bottom_out/top_out           straight passthrough to the other side
//   ipin_out                           grid input pins
//   cfg_done, cfg_err                  commit seen / last commit had a bad shift count

// One pin's select mux. Select codes at or above MUX_SIZE read the zero padding.
module cby_ipin_mux #(
    parameter int MUX_SIZE = 8,
    parameter int SEL_W    = 3
) (
    input  logic [MUX_SIZE-1:0] taps,
    input  logic [SEL_W-1:0]    sel,
    output logic                ipin
);
    localparam int DEPTH = 1 << SEL_W;

    logic [DEPTH-1:0] padded;

    assign padded = DEPTH'(taps);
    assign ipin   = padded[sel];
endmodule

module cby_cfg_shadow_mux #(
    parameter int CHAN_WIDTH = 20,
    parameter int NUM_IPIN   = 12,
    parameter int TAPS       = 4,
    parameter int TAP_STRIDE = 5
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  config_enable,
    input  logic                  ccff_head,
    output logic                  ccff_tail,
    input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
    input  logic [CHAN_WIDTH-1:0] chany_top_in,
    output logic [CHAN_WIDTH-1:0] chany_bottom_out,
    output logic [CHAN_WIDTH-1:0] chany_top_out,
    output logic [NUM_IPIN-1:0]   ipin_out,
    output logic                  cfg_done,
    output logic                  cfg_err
);
    localparam int MUX_SIZE = 2 * TAPS;
    localparam int SEL_W    = (MUX_SIZE > 1) ? $clog2(MUX_SIZE) : 1;
    localparam int L        = NUM_IPIN * SEL_W;
    localparam int CNT_W    = $clog2(L) + 2;
    localparam logic [CNT_W-1:0] CNT_L   = CNT_W'(L);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [L-1:0]     cfg;
    logic [L-1:0]     active;
    logic [CNT_W-1:0] cnt;
    logic             en_d;
    logic             commit;

    // Falling edge of config_enable, seen one clock late through en_d.
    assign commit = en_d & ~config_enable;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            cfg      <= '0;
            active   <= '0;
            cnt      <= '0;
            en_d     <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            en_d <= config_enable;
            if (config_enable) begin
                // The shift form also works for a single-bit chain.
                cfg <= (cfg << 1) | L'(ccff_head);
                if (cnt != CNT_MAX)
                    cnt <= cnt + CNT_W'(1);
                // First shift of a new session drops the previous done.
                if (!en_d)
                    cfg_done <= 1'b0;
            end
            if (commit) begin
                active   <= cfg;
                cfg_err  <= (cnt != CNT_L);
                cnt      <= '0;
                cfg_done <= 1'b1;
            end
        end
    end

    assign ccff_tail        = cfg[L-1];
    assign chany_bottom_out = chany_top_in;
    assign chany_top_out    = chany_bottom_in;

    logic [NUM_IPIN-1:0][SEL_W-1:0]    pin_sel;
    logic [NUM_IPIN-1:0][MUX_SIZE-1:0] pin_taps;

    for (genvar i = 0; i < NUM_IPIN; i++) begin : g_pin
        // A pin's select is stored MSB-first in its cfg slice, so the
        // earliest-shifted bit of the slice is the select LSB.
        for (genvar b = 0; b < SEL_W; b++) begin : g_sel
            assign pin_sel[i][b] = active[i*SEL_W + SEL_W-1-b];
        end
        for (genvar t = 0; t < TAPS; t++) begin : g_tap
            localparam int K = (i + t*TAP_STRIDE) % CHAN_WIDTH;
            assign pin_taps[i][2*t]   = chany_bottom_in[K];
            assign pin_taps[i][2*t+1] = chany_top_in[K];
        end
        cby_ipin_mux #(
            .MUX_SIZE (MUX_SIZE),
            .SEL_W    (SEL_W)
        ) u_mux (
            .taps (pin_taps[i]),
            .sel  (pin_sel[i]),
            .ipin (ipin_out[i])
        );
    end
endmodule

// File: tb/tb_cby_cfg_shadow_mux.sv
// Directed bench for cby_cfg_shadow_mux. Stimulus queues expected values
// tagged with the current cycle; a monitor compares them on the following
// falling clock edge. A second instance with TAPS=3 covers non-power-of-two
// mux sizes.
module tb_cby_cfg_shadow_mux;
    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        config_enable;
    logic        ccff_head;
    logic [19:0] bot, top;

    logic        tail, done, err;
    logic [19:0] bot_out, top_out;
    logic [11:0] ipin;
    logic        tail3, done3, err3;
    logic [19:0] bot_out3, top_out3;
    logic [11:0] ipin3;

    cby_cfg_shadow_mux dut (
        .prog_clk(prog_clk), .pReset(pReset), .config_enable(config_enable),
        .ccff_head(ccff_head), .ccff_tail(tail),
        .chany_bottom_in(bot), .chany_top_in(top),
        .chany_bottom_out(bot_out), .chany_top_out(top_out),
        .ipin_out(ipin), .cfg_done(done), .cfg_err(err)
    );

    cby_cfg_shadow_mux #(.TAPS(3)) dut3 (
        .prog_clk(prog_clk), .pReset(pReset), .config_enable(config_enable),
        .ccff_head(ccff_head), .ccff_tail(tail3),
        .chany_bottom_in(bot), .chany_top_in(top),
        .chany_bottom_out(bot_out3), .chany_top_out(top_out3),
        .ipin_out(ipin3), .cfg_done(done3), .cfg_err(err3)
    );

    always #5 prog_clk = ~prog_clk;

    int cyc = 0;
    always @(posedge prog_clk) cyc++;

    typedef struct {
        int          id;
        logic [31:0] exp;
        int          due;
        string       name;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;

    localparam int T_TAIL = 0, T_DONE = 1, T_ERR = 2, T_IPIN = 3, T_IPIN3 = 4,
                   T_IPIN0 = 5, T_TOPO = 6, T_BOTO = 7, T_TAIL3 = 8,
                   T_DONE3 = 9, T_ERR3 = 10, T_TOPO3 = 11, T_BOTO3 = 12;

    function automatic logic [31:0] actual(input int id);
        case (id)
            T_TAIL:  return {31'd0, tail};
            T_DONE:  return {31'd0, done};
            T_ERR:   return {31'd0, err};
            T_IPIN:  return {20'd0, ipin};
            T_IPIN3: return {20'd0, ipin3};
            T_IPIN0: return {31'd0, ipin[0]};
            T_TOPO:  return {12'd0, top_out};
            T_BOTO:  return {12'd0, bot_out};
            T_TAIL3: return {31'd0, tail3};
            T_DONE3: return {31'd0, done3};
            T_ERR3:  return {31'd0, err3};
            T_TOPO3: return {12'd0, top_out3};
            T_BOTO3: return {12'd0, bot_out3};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: drain every expectation due by this cycle on the falling edge.
    chk_t        mon_it;
    logic [31:0] mon_act;
    initial begin
        forever begin
            @(negedge prog_clk);
            while (q.size() != 0 && q[0].due <= cyc) begin
                mon_it  = q.pop_front();
                mon_act = actual(mon_it.id);
                checks++;
                if (mon_act !== mon_it.exp) begin
                    errors++;
                    $display("FAIL %s: actual %0h required %0h", mon_it.name, mon_act, mon_it.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic expect_v(input int id, input logic [31:0] exp, input string name);
        chk_t c;
        c.id = id; c.exp = exp; c.due = cyc; c.name = name;
        q.push_back(c);
    endtask

    task automatic shift_bit(input logic b);
        config_enable = 1'b1;
        ccff_head     = b;
        step();
    endtask

    task automatic commit();
        config_enable = 1'b0;
        step();
    endtask

    task automatic load36(input logic [35:0] c);
        for (int n = 35; n >= 0; n--) shift_bit(c[n]);
    endtask

    // Pin i's select MSB sits at cfg[i*3], LSB at cfg[i*3+2].
    function automatic logic [35:0] cfg_from_sel(input logic [11:0][2:0] s);
        logic [35:0] c;
        c = '0;
        for (int i = 0; i < 12; i++)
            for (int b = 0; b < 3; b++)
                c[i*3 + 2 - b] = s[i][b];
        return c;
    endfunction

    logic [11:0][2:0] sel;
    logic [71:0]      stream;
    logic [39:0]      tr;

    initial begin
        pReset = 1'b1; config_enable = 1'b0; ccff_head = 1'b0;
        bot = 20'h00A5C; top = 20'h3C001;
        step(); step();
        // Reset state: all selects 0 so each pin follows its own bottom track.
        expect_v(T_TAIL, 0, "rst_tail");
        expect_v(T_DONE, 0, "rst_done");
        expect_v(T_ERR, 0, "rst_err");
        expect_v(T_IPIN, 32'hA5C, "rst_ipin");
        expect_v(T_TOPO, 32'h00A5C, "pass_top_out");
        expect_v(T_BOTO, 32'h3C001, "pass_bot_out");
        step();
        pReset = 1'b0;
        bot = 20'h00001; top = 20'h0;
        step();

        // Short session of 35 ones: commits with a bad count, pin 0 select 7.
        for (int n = 0; n < 35; n++) shift_bit(1'b1);
        commit();
        expect_v(T_DONE, 1, "short_done");
        expect_v(T_ERR, 1, "short_err");
        expect_v(T_IPIN, 0, "short_ipin");
        step();

        // Start another session, then hit reset in the middle of it.
        shift_bit(1'b1);
        expect_v(T_DONE, 0, "sess_start_done_clr");
        for (int n = 0; n < 9; n++) shift_bit(1'b1);
        expect_v(T_TAIL, 1, "pre_rst_tail");
        expect_v(T_ERR, 1, "pre_rst_err");
        expect_v(T_IPIN0, 0, "pre_rst_ipin0");
        step();
        pReset = 1'b1;
        expect_v(T_TAIL, 0, "midshift_rst_tail");
        expect_v(T_DONE, 0, "midshift_rst_done");
        expect_v(T_ERR, 0, "midshift_rst_err");
        expect_v(T_IPIN0, 1, "midshift_rst_ipin0");
        step();
        pReset = 1'b0; config_enable = 1'b0; bot = '0; top = '0;
        step();

        // Pin 0 select 3 -> chany_top_in[5].
        sel = '0; sel[0] = 3'd3;
        load36(cfg_from_sel(sel));
        expect_v(T_DONE, 0, "pre_commit_done");
        commit();
        expect_v(T_DONE, 1, "commit_done");
        expect_v(T_ERR, 0, "commit_err");
        expect_v(T_IPIN, 0, "commit_ipin_idle");
        step();
        top = 20'h00020;
        expect_v(T_IPIN, 32'h001, "top5_hi");
        step();
        top = 20'h0;
        expect_v(T_IPIN, 32'h000, "top5_lo");
        step();
        bot = 20'h00008;
        expect_v(T_IPIN, 32'h008, "pin3_bot3");
        step();
        bot = 20'h0;
        // Every other track must leave pin 0 alone: tr = {top, bot}.
        for (int j = 0; j < 40; j++) begin
            if (j != 25) begin
                tr = 40'd1 << j;
                {top, bot} = tr;
                expect_v(T_IPIN0, 0, "pin0_isolation");
                step();
            end
        end
        top = 20'h00020; bot = '0;
        step();

        // Reprogram pin 0 to select 1 (top[0]=0); pins must not move while shifting.
        sel = '0; sel[0] = 3'd1;
        stream[35:0] = cfg_from_sel(sel);
        for (int n = 35; n >= 0; n--) begin
            shift_bit(stream[n]);
            expect_v(T_IPIN, 32'h001, "noglitch_shift");
        end
        commit();
        expect_v(T_IPIN, 0, "noglitch_commit");
        expect_v(T_ERR, 0, "noglitch_err");
        step();

        // 35 shifts then commit flags a count error.
        for (int n = 0; n < 35; n++) shift_bit(1'b0);
        commit();
        expect_v(T_ERR, 1, "cnt35_err");
        expect_v(T_DONE, 1, "cnt35_done");
        step();

        // A correct session clears the error again.
        sel = '0; sel[0] = 3'd3;
        load36(cfg_from_sel(sel));
        commit();
        expect_v(T_ERR, 0, "cnt36_err_clr");
        expect_v(T_DONE, 1, "cnt36_done");
        expect_v(T_IPIN, 32'h001, "cnt36_ipin");
        step();

        // Chain continuity: the tail repeats the stream 36 edges later.
        stream = {36'h9_A5C3_1E7B, 36'h3_0F0F_5AA5};
        for (int m = 0; m < 72; m++) begin
            shift_bit(stream[71-m]);
            if (m >= 35 && m <= 70)
                expect_v(T_TAIL, {31'd0, stream[71-(m-35)]}, "chain_tail");
        end
        commit();
        expect_v(T_ERR, 1, "cnt72_err");
        step();

        // Selects 5/6/7 on both the TAPS=4 and TAPS=3 instances.
        sel = '0;
        sel[0] = 3'd5; sel[1] = 3'd6; sel[2] = 3'd7; sel[3] = 3'd5; sel[11] = 3'd5;
        load36(cfg_from_sel(sel));
        commit();
        expect_v(T_ERR, 0, "taps_err");
        expect_v(T_DONE3, 1, "taps3_done");
        expect_v(T_ERR3, 0, "taps3_err");
        expect_v(T_TAIL, 1, "taps_tail");
        expect_v(T_TAIL3, 1, "taps3_tail");
        step();
        bot = 20'hFFFFF; top = 20'hFFFFF;
        expect_v(T_IPIN, 32'hFFF, "taps4_all1");
        expect_v(T_IPIN3, 32'hFF9, "taps3_all1");
        expect_v(T_TOPO3, 32'hFFFFF, "taps3_pass_top");
        expect_v(T_BOTO3, 32'hFFFFF, "taps3_pass_bot");
        step();
        bot = 20'hFFFFF; top = 20'h0;
        expect_v(T_IPIN, 32'h7F2, "taps4_bot1");
        expect_v(T_IPIN3, 32'h7F0, "taps3_bot1");
        step();
        bot = 20'h0; top = 20'h02000;
        expect_v(T_IPIN, 32'h008, "taps4_top13");
        expect_v(T_IPIN3, 32'h008, "taps3_top13");
        step();
        top = 20'h20000;
        expect_v(T_IPIN, 32'h004, "taps4_top17");
        expect_v(T_IPIN3, 32'h000, "taps3_sel7_zero");
        step();
        top = 20'h00400;
        expect_v(T_IPIN, 32'h001, "taps4_top10");
        expect_v(T_IPIN3, 32'h001, "taps3_top10");
        step();
        top = 20'h00002;
        expect_v(T_IPIN, 32'h800, "taps4_wrap");
        expect_v(T_IPIN3, 32'h800, "taps3_wrap");
        step();

        step(); step();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
